// File: rtl/controle_multiciclo_pkg.sv
// ----------------------------------------------------------------------------
// pkg_controle
//   Shared encodings for the multicycle RISC-V main control:
//   state codes, opcode constants, ALUOp codes and datapath select values.
//   No ports (package).
//   Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package pkg_controle;

  // State encodings
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_MEMADR   = 4'd3;
  localparam logic [3:0] ST_MEMREAD  = 4'd4;
  localparam logic [3:0] ST_MEMWB    = 4'd5;
  localparam logic [3:0] ST_MEMWRITE = 4'd6;
  localparam logic [3:0] ST_EXEC_R   = 4'd7;
  localparam logic [3:0] ST_EXEC_I   = 4'd8;
  localparam logic [3:0] ST_ALUWB    = 4'd9;
  localparam logic [3:0] ST_BEQ      = 4'd10;
  localparam logic [3:0] ST_TRAP     = 4'd11;

  typedef enum logic [3:0] {
    IDLE     = ST_IDLE,
    FETCH    = ST_FETCH,
    DECODE   = ST_DECODE,
    MEMADR   = ST_MEMADR,
    MEMREAD  = ST_MEMREAD,
    MEMWB    = ST_MEMWB,
    MEMWRITE = ST_MEMWRITE,
    EXEC_R   = ST_EXEC_R,
    EXEC_I   = ST_EXEC_I,
    ALUWB    = ST_ALUWB,
    BEQ      = ST_BEQ,
    TRAP     = ST_TRAP
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 / funct7 values of the supported instructions
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // ALUOp codes
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  // Datapath selects
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic       IORD_PC     = 1'b0;
  localparam logic       IORD_ALUOUT = 1'b1;
  localparam logic       PCSRC_ALU   = 1'b0;
  localparam logic       PCSRC_ALUOUT = 1'b1;
  localparam logic       RES_ALUOUT  = 1'b0;
  localparam logic       RES_MEM     = 1'b1;

endpackage

`default_nettype wire

// File: rtl/controle_multiciclo_decodificador_opcode.sv
// ----------------------------------------------------------------------------
// decodificador_opcode
//   Combinational instruction-class decoder.
//   Ports:
//     opcode_i, funct3_i, funct7_i  - instruction fields from the IR
//     is_load_o .. is_beq_o         - decode class flags
//     legal_o                       - encoding is supported
//     i_alu_op_o                    - ALUOp to use for the I-type ALU ops
//   Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module decodificador_opcode
  import pkg_controle::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_r_o,
  output logic       is_i_o,
  output logic       is_beq_o,
  output logic       legal_o,
  output logic [1:0] i_alu_op_o
);

  logic w_r_legal;
  logic w_i_legal;

  always_comb begin
    is_load_o  = (opcode_i == OP_LOAD);
    is_store_o = (opcode_i == OP_STORE);
    is_r_o     = (opcode_i == OP_R);
    is_i_o     = (opcode_i == OP_I);
    is_beq_o   = (opcode_i == OP_BRANCH) && (funct3_i == F3_BEQ);

    // add/sub share funct3; or/srl only exist with a zero funct7
    w_r_legal = ((funct3_i == F3_ADD) && ((funct7_i == F7_BASE) || (funct7_i == F7_SUB)))
             || ((funct3_i == F3_OR)  &&  (funct7_i == F7_BASE))
             || ((funct3_i == F3_SRL) &&  (funct7_i == F7_BASE));

    // funct7 of I-type is immediate bits, so it never takes part here
    w_i_legal = (funct3_i == F3_ADD) || (funct3_i == F3_OR) || (funct3_i == F3_AND);

    legal_o = is_load_o || is_store_o || is_beq_o
           || (is_r_o && w_r_legal) || (is_i_o && w_i_legal);

    case (funct3_i)
      F3_OR:   i_alu_op_o = ALUOP_RTYPE;
      F3_AND:  i_alu_op_o = ALUOP_AND;
      default: i_alu_op_o = ALUOP_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/controle_multiciclo.sv
// ----------------------------------------------------------------------------
// controle_multiciclo
//   Multicycle main control FSM for a RISC-V datapath with one shared ALU
//   and a unified memory port. Also counts retired instructions and flags
//   unsupported encodings.
//   Ports:
//     clk, rst_n (sync, active-low)
//     opcode/funct3/funct7 - IR fields; zero - ALU zero; mem_ready - handshake
//     mem_req/mem_we/iord/ir_write/pc_en/pc_src/alu_src_a/alu_src_b/alu_op/
//     result_src/reg_write - datapath controls
//     illegal - sticky unsupported-instruction flag; instret - retire count
//   Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module controle_multiciclo
  import pkg_controle::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_en,
  output logic        pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        result_src,
  output logic        reg_write,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t      state_q, state_d;
  logic        illegal_q;
  logic [31:0] instret_q;

  logic        w_is_load, w_is_store, w_is_r, w_is_i, w_is_beq, w_legal;
  logic [1:0]  w_i_alu_op;
  logic        w_retire;

  decodificador_opcode u_dec (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7_i   (funct7),
    .is_load_o  (w_is_load),
    .is_store_o (w_is_store),
    .is_r_o     (w_is_r),
    .is_i_o     (w_is_i),
    .is_beq_o   (w_is_beq),
    .legal_o    (w_legal),
    .i_alu_op_o (w_i_alu_op)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      illegal_q <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_d == TRAP) illegal_q <= 1'b1;
      if (w_retire)        instret_q <= instret_q + 32'd1;
    end
  end

  // An instruction retires on the last cycle of its sequence
  assign w_retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ)
                 || ((state_q == MEMWRITE) && mem_ready);

  assign illegal = illegal_q;
  assign instret = instret_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = IORD_PC;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    reg_write  = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        // PC+4 is computed every FETCH cycle, committed only with the IR load
        mem_req   = 1'b1;
        iord      = IORD_PC;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        pc_src    = PCSRC_ALU;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = DECODE;
      end

      DECODE: begin
        // OldPC + imm: branch target parked in ALUOut for BEQ
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        if (!w_legal)                     state_d = TRAP;
        else if (w_is_load || w_is_store) state_d = MEMADR;
        else if (w_is_r)                  state_d = EXEC_R;
        else if (w_is_i)                  state_d = EXEC_I;
        else if (w_is_beq)                state_d = BEQ;
        else                              state_d = TRAP;
      end

      MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
        state_d   = w_is_load ? MEMREAD : MEMWRITE;
      end

      MEMREAD: begin
        mem_req = 1'b1;
        iord    = IORD_ALUOUT;
        if (mem_ready) state_d = MEMWB;
      end

      MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        state_d    = FETCH;
      end

      MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = IORD_ALUOUT;
        if (mem_ready) state_d = FETCH;
      end

      EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_RTYPE;
        state_d   = ALUWB;
      end

      EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = w_i_alu_op;
        state_d   = ALUWB;
      end

      ALUWB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        state_d    = FETCH;
      end

      BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
        state_d   = FETCH;
      end

      TRAP: state_d = TRAP;

      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle main control FSM for the RISC-V datapath. It sequences fetch, decode, execute, memory and writeback over a single shared ALU, PC, instruction register and unified memory port. It drives the 2-bit ALUOp consumed by the ALU control decoder, plus all mux selects and write enables. It also counts retired instructions and flags unsupported encodings.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier for mem_req.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR and OldPC.
- pc_en  out  1  PC load enable.
- pc_src  out  1  0 = ALU result, 1 = ALUOut.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  00 = ADD, 01 = SUB, 10 = R-type decode, 11 = AND.
- result_src  out  1  0 = ALUOut, 1 = memory data.
- reg_write  out  1  register file write enable.
- illegal  out  1  sticky unsupported-instruction flag.
- instret  out  32  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BEQ, TRAP.
- All outputs not listed for a state are 0.
- IDLE
  - Drives all outputs 0.
  - Always moves to FETCH.
- FETCH
  - Drives mem_req=1, iord=0, alu_src_a=00, alu_src_b=10, alu_op=00, pc_src=0.
  - ir_write and pc_en equal mem_ready.
  - Holds until mem_ready, then moves to DECODE.
- DECODE
  - Drives alu_src_a=01, alu_src_b=01, alu_op=00. This computes the branch target into ALUOut.
  - Next state by decode class:
    - opcode 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXEC_R, legal only for: funct3=000 with funct7 0000000 (add) or 0100000 (sub); funct3=110 with funct7 0 (or); funct3=101 with funct7 0 (srl).
    - 0010011 → EXEC_I, legal only for funct3 000 (addi), 110 (ori), 111 (andi).
    - 1100011 with funct3=000 (beq) → BEQ.
    - Anything else → TRAP.
- MEMADR
  - Drives alu_src_a=10, alu_src_b=01, alu_op=00.
  - Next state: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD
  - Drives mem_req=1, iord=1.
  - Moves to MEMWB on mem_ready.
- MEMWB
  - Drives reg_write=1, result_src=1.
  - Moves to FETCH.
- MEMWRITE
  - Drives mem_req=1, mem_we=1, iord=1.
  - Moves to FETCH on mem_ready.
- EXEC_R
  - Drives alu_src_a=10, alu_src_b=00, alu_op=10.
  - Moves to ALUWB.
- EXEC_I
  - Drives alu_src_a=10, alu_src_b=01.
  - alu_op: 00 for addi, 10 for ori, 11 for andi. addi never uses 10, because its funct7 field is immediate bits.
  - Moves to ALUWB.
- ALUWB
  - Drives reg_write=1, result_src=0.
  - Moves to FETCH.
- BEQ
  - Drives alu_src_a=10, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_en equals zero.
  - Moves to FETCH.
- TRAP
  - Sets illegal=1.
  - Stays in TRAP until reset; all other outputs 0.
- instret increments by 1 on leaving MEMWB, MEMWRITE (with mem_ready), ALUWB or BEQ. It wraps modulo 2^32.

## Timing
- Reset
  - While rst_n=0 at a clock edge: state becomes IDLE, illegal becomes 0, instret becomes 0.
  - Consequently every output is 0 in the cycle after a reset edge.
  - First mem_req appears 2 cycles after the first edge with rst_n=1.
  - Reset mid-access drops mem_req at the next edge, regardless of mem_ready.
- Outputs are Moore decodes of the state register, except ir_write and pc_en in FETCH and pc_en in BEQ, which are combinational on mem_ready and zero.
- Cycle counts with zero-wait memory (mem_ready high on the first request cycle):
  - R-type / I-type: 4 cycles.
  - beq: 3 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle mem_ready stays low adds one cycle.
- Handshake
  - mem_req, mem_we and iord stay stable until the cycle that sees mem_ready.
  - mem_ready is ignored while mem_req=0.
- opcode, funct3 and funct7 are sampled only in DECODE, MEMADR and EXEC_I. The IR must hold them stable from the end of FETCH.

## Structure
- Package pkg_controle holds:
  - State encodings (4-bit localparams).
  - Opcode constants.
  - ALUOp codes 00/01/10/11.
  - alu_src_a, alu_src_b, iord, pc_src and result_src select encodings.
- One sub-module, decodificador_opcode: combinational opcode/funct → {is_load, is_store, is_r, is_i, is_beq, legal, i_alu_op[1:0]}.
- Next-state logic, output decode and instret counter live in the top.

## Test plan
- Reset and first fetch
  - Stimulus: rst_n low 3 cycles, then high.
  - Required: all outputs 0 and instret=0 during reset. mem_req=1, iord=0, alu_src_b=10 on the 2nd cycle after release.
- add with zero-wait memory
  - Stimulus: opcode 0110011, funct3 000, funct7 0, mem_ready tied high.
  - Required: states FETCH, DECODE, EXEC_R (alu_op=10), ALUWB (reg_write=1). instret goes 0→1 after 4 cycles.
- lw with wait states
  - Stimulus: mem_ready low for 2 cycles in MEMREAD.
  - Required: mem_req and iord=1 held 3 cycles. MEMWB has result_src=1. Total 7 cycles.
- beq
  - Stimulus: beq with zero=1, then beq with zero=0.
  - Required: in BEQ, alu_op=01 and pc_src=1 both times. pc_en=1 for the first, 0 for the second.
- addi, andi, sub
  - Stimulus: addi with funct7 field 0100000; andi; sub.
  - Required: alu_op 00 for addi, 11 for andi, 10 for sub.
- Illegal encodings
  - Stimulus: R-type with funct3=111, and opcode 1101111.
  - Required: TRAP follows DECODE; illegal=1 sticky; instret frozen. rst_n low clears illegal and returns to IDLE.
